// File: rtl/wb_dma_mem_slave_pkg.sv
// ----------------------------------------------------------------------------
// wb_pkg
//   Shared Wishbone B3 encodings and helpers for the DMA memory slave.
//   CTI_* : cycle type identifiers (classic, incrementing burst, end-of-burst)
//   BTE_* : burst type extensions (linear, wrap4, wrap8, wrap16)
//   wb_state_t   : slave FSM state encoding
//   byte_lane_we : commit rule for one SRAM byte lane
// ----------------------------------------------------------------------------
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLASSIC = 2'd1,
        ST_BURST   = 2'd2
    } wb_state_t;

    // A byte lane is committed only on a beat that is being acknowledged
    // while the master still holds the request, for a write with that lane
    // selected. Error beats never reach here because they carry no ack.
    function automatic logic byte_lane_we(input logic ack,
                                          input logic req,
                                          input logic we,
                                          input logic sel);
        return ack & req & we & sel;
    endfunction

endpackage

// File: rtl/wb_dma_mem_slave_addr_gen.sv
// ----------------------------------------------------------------------------
// wb_burst_addr_gen
//   Combinational next-word-address generator for Wishbone incrementing
//   bursts.
//   i_addr  : current word address (MEM_AW bits)
//   i_bte   : burst type extension
//   o_next  : word address of the following beat
//   o_carry : linear burst stepped past the last word of the window
// ----------------------------------------------------------------------------
module wb_burst_addr_gen
    import wb_pkg::*;
#(
    parameter int MEM_AW = 10
) (
    input  logic [MEM_AW-1:0] i_addr,
    input  logic [1:0]        i_bte,
    output logic [MEM_AW-1:0] o_next,
    output logic              o_carry
);

    logic [MEM_AW:0] w_inc;

    assign w_inc = {1'b0, i_addr} + {{MEM_AW{1'b0}}, 1'b1};

    // Wrapping bursts keep the upper bits and roll only the low 2/3/4 bits;
    // only a linear burst can carry out of the window.
    always_comb begin
        o_next  = w_inc[MEM_AW-1:0];
        o_carry = 1'b0;
        case (i_bte)
            BTE_WRAP4:  o_next = {i_addr[MEM_AW-1:2], w_inc[1:0]};
            BTE_WRAP8:  o_next = {i_addr[MEM_AW-1:3], w_inc[2:0]};
            BTE_WRAP16: o_next = {i_addr[MEM_AW-1:4], w_inc[3:0]};
            default:    o_carry = w_inc[MEM_AW];
        endcase
    end

endmodule

// File: rtl/wb_dma_mem_slave.sv
// ----------------------------------------------------------------------------
// wb_dma_mem_slave
//   Wishbone B3 slave SRAM serving the SD-card controller's DMA master.
//   Classic cycles and registered-feedback incrementing bursts (CTI/BTE);
//   out-of-window accesses terminate with ERR.
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   wb_adr_i              : byte address (bits [1:0] ignored)
//   wb_dat_i / wb_sel_i   : write data / byte enables
//   wb_we_i               : 1 = write
//   wb_cyc_i / wb_stb_i   : cycle valid / strobe
//   wb_cti_i / wb_bte_i   : cycle type / burst type
//   wb_dat_o              : read data, valid while wb_ack_o
//   wb_ack_o / wb_err_o   : normal / error termination
//   wb_rty_o              : never asserted
// ----------------------------------------------------------------------------
module wb_dma_mem_slave
    import wb_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_AW     = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic                    wb_we_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic [2:0]              wb_cti_i,
    input  logic [1:0]              wb_bte_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic                    wb_rty_o
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** MEM_AW;

    wb_state_t             r_state;
    logic                  r_ack;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_dat;
    logic [MEM_AW-1:0]     r_addr;

    logic                  w_req;
    logic [ADDR_WIDTH-1:0] w_offset;
    logic                  w_in_win;
    logic [MEM_AW-1:0]     w_idx;
    logic [MEM_AW-1:0]     w_gen_next;
    logic                  w_gen_carry;
    logic [MEM_AW-1:0]     w_rd_addr;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_unused;

    assign w_req    = wb_cyc_i & wb_stb_i;
    // BASE_ADDR is aligned to the window, so a single subtract-and-test of
    // the upper offset bits also rejects addresses below the base.
    assign w_offset = wb_adr_i - BASE_ADDR;
    assign w_in_win = (w_offset[ADDR_WIDTH-1:MEM_AW+2] == '0);
    assign w_idx    = w_offset[MEM_AW+1:2];
    assign w_unused = ^w_offset[1:0];

    wb_burst_addr_gen #(
        .MEM_AW (MEM_AW)
    ) u_addr_gen (
        .i_addr  (r_addr),
        .i_bte   (wb_bte_i),
        .o_next  (w_gen_next),
        .o_carry (w_gen_carry)
    );

    // Read address for the beat that will be acknowledged next cycle: the
    // counter successor while a burst streams, otherwise the bus address.
    always_comb begin
        w_rd_addr = w_idx;
        if (r_state == ST_BURST && r_ack) begin
            w_rd_addr = w_gen_next;
        end
    end

    // Per-byte-lane SRAM. The write uses the address of the beat being
    // acknowledged (r_addr) and the data the master holds during that ack.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [7:0] r_mem [DEPTH];

        always_ff @(posedge clk) begin
            if (byte_lane_we(r_ack, w_req, wb_we_i, wb_sel_i[k])) begin
                r_mem[r_addr] <= wb_dat_i[8*k +: 8];
            end
        end

        assign w_rd_data[8*k +: 8] = r_mem[w_rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= '0;
            r_addr  <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req && !r_ack && !r_err) begin
                        if (!w_in_win) begin
                            r_err   <= 1'b1;
                            r_state <= ST_CLASSIC;
                        end else begin
                            r_ack   <= 1'b1;
                            r_addr  <= w_idx;
                            r_dat   <= w_rd_data;
                            r_state <= (wb_cti_i == CTI_INCR) ? ST_BURST : ST_CLASSIC;
                        end
                    end
                end

                // Single-cycle termination; the IDLE cycle that follows
                // guarantees a low cycle before the next ack.
                ST_CLASSIC: begin
                    r_state <= ST_IDLE;
                end

                ST_BURST: begin
                    if (!wb_cyc_i) begin
                        r_state <= ST_IDLE;
                    end else if (!wb_stb_i) begin
                        // Wait state: drop the speculative ack and resume
                        // from the bus address when the strobe returns.
                        r_state <= ST_BURST;
                    end else if (r_ack) begin
                        if (wb_cti_i == CTI_INCR) begin
                            if (w_gen_carry) begin
                                r_err   <= 1'b1;
                                r_state <= ST_CLASSIC;
                            end else begin
                                r_ack  <= 1'b1;
                                r_addr <= w_gen_next;
                                r_dat  <= w_rd_data;
                            end
                        end else begin
                            // End-of-burst beat is being acked right now.
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        if (!w_in_win) begin
                            r_err   <= 1'b1;
                            r_state <= ST_CLASSIC;
                        end else begin
                            r_ack  <= 1'b1;
                            r_addr <= w_idx;
                            r_dat  <= w_rd_data;
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The registered ack/err is qualified by the live request so a beat
    // acked speculatively in a burst disappears in the very cycle the master
    // drops stb (wait state, or stb drop together with cti=111) or cyc.
    assign wb_ack_o = r_ack & w_req;
    assign wb_err_o = r_err & w_req;
    assign wb_dat_o = r_dat;
    assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_dma_mem_slave.sv
module tb_wb_dma_mem_slave;
    import wb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic        is_err;
        logic        chk_dat;
        logic [31:0] dat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] b_adr [8];
    logic [31:0] b_dat [8];

    wb_dma_mem_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_AW     (10),
        .BASE_ADDR  (32'h8000_0000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_sel_i (wb_sel_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_cti_i (wb_cti_i),
        .wb_bte_i (wb_bte_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .wb_rty_o (wb_rty_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input logic is_err, input logic chk_dat, input logic [31:0] dat);
        exp_t e;
        e.is_err  = is_err;
        e.chk_dat = chk_dat;
        e.dat     = dat;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every terminated beat pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (wb_ack_o || wb_err_o || wb_rty_o)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 32'({wb_rty_o, wb_err_o, wb_ack_o}), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_kind", 32'({wb_rty_o, wb_err_o, wb_ack_o}),
                          e.is_err ? 32'd2 : 32'd1);
                    if (e.chk_dat) check("resp_data", wb_dat_o, e.dat);
                end
            end
        end
    end

    task automatic wb_single(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, output int lat);
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
        wb_cti_i = CTI_CLASSIC; wb_bte_i = BTE_LINEAR;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wb_ack_o || wb_err_o) break;
            lat++;
        end
        @(posedge clk); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        int lat;
        push(1'b0, 1'b0, 32'd0);
        wb_single(1'b1, adr, dat, sel, lat);
        check("write_latency", 32'(lat), 32'd1);
    endtask

    task automatic do_read(input logic [31:0] adr, input logic [31:0] exp_dat);
        int lat;
        push(1'b0, 1'b1, exp_dat);
        wb_single(1'b0, adr, 32'd0, 4'hF, lat);
        check("read_latency", 32'(lat), 32'd1);
    endtask

    task automatic do_err(input logic we, input logic [31:0] adr);
        int lat;
        push(1'b1, 1'b0, 32'd0);
        wb_single(we, adr, 32'hDEAD_BEEF, 4'hF, lat);
        check("err_latency", 32'(lat), 32'd1);
    endtask

    task automatic drive_beat(input int i, input int n);
        wb_adr_i = b_adr[i];
        wb_dat_i = b_dat[i];
        wb_cti_i = (i == n - 1) ? CTI_EOB : CTI_INCR;
    endtask

    // Registered-feedback burst master: advances one beat per sampled ack,
    // optionally inserting one stb-low cycle after beat gap_after, dropping
    // cyc after beat drop_after, or holding the request one cycle past EOB.
    task automatic wb_burst(input logic we, input logic [1:0] bte, input int n,
                            input int gap_after, input int drop_after, input bit hold,
                            output int cycles);
        int   beat;
        bit   gapped;
        bit   done;
        logic a;
        beat = 0; gapped = 0; done = 0; cycles = 0;
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_bte_i = bte;  wb_sel_i = 4'hF;
        drive_beat(0, n);
        while (cycles < 100) begin
            @(negedge clk);
            a = wb_ack_o;
            cycles++;
            if (!wb_stb_i) check("gap_ack_low", 32'(a), 32'd0);
            @(posedge clk); #1;
            if (a) begin
                beat++;
                if (beat == n || beat == drop_after) begin
                    if (hold) begin
                        @(negedge clk);
                        check("eob_ack_low", 32'(wb_ack_o), 32'd0);
                        @(posedge clk); #1;
                    end
                    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
                    done = 1;
                    break;
                end
                drive_beat(beat, n);
                if (beat == gap_after && !gapped) begin
                    wb_stb_i = 1'b0;
                    gapped   = 1;
                end
            end else if (!wb_stb_i) begin
                wb_stb_i = 1'b1;
            end
        end
        if (!done) begin
            check("burst_timeout", 32'd0, 32'd1);
            wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        rst_n = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = CTI_CLASSIC; wb_bte_i = BTE_LINEAR;
        repeat (3) @(negedge clk);
        check("reset_ack", 32'(wb_ack_o), 32'd0);
        check("reset_err", 32'(wb_err_o), 32'd0);
        check("reset_dat", wb_dat_o, 32'd0);
        rst_n = 1'b1;

        // Classic write, partial-lane overwrite, readback.
        do_write(32'h8000_0010, 32'hFFFF_FFFF, 4'hF);
        do_write(32'h8000_0010, 32'hA5A5_1234, 4'b0011);
        do_read (32'h8000_0010, 32'hFFFF_1234);
        check("rty_low", 32'(wb_rty_o), 32'd0);

        // Wrap4 incrementing read from word 3: words 3,0,1,2.
        for (int i = 0; i < 4; i++) do_write(32'h8000_0000 + 32'(4 * i), 32'h1111_0000 + 32'(i), 4'hF);
        b_adr[0] = 32'h8000_000C; b_adr[1] = 32'h8000_0000;
        b_adr[2] = 32'h8000_0004; b_adr[3] = 32'h8000_0008;
        push(1'b0, 1'b1, 32'h1111_0003);
        push(1'b0, 1'b1, 32'h1111_0000);
        push(1'b0, 1'b1, 32'h1111_0001);
        push(1'b0, 1'b1, 32'h1111_0002);
        wb_burst(1'b0, BTE_WRAP4, 4, 0, 0, 1'b1, cyc);
        check("wrap4_cycles", 32'(cyc), 32'd5);

        // Linear 8-beat write with a wait state after beat 3.
        for (int i = 0; i < 8; i++) begin
            b_adr[i] = 32'h8000_0000 + 32'(4 * i);
            b_dat[i] = 32'h2222_0000 + 32'(i);
            push(1'b0, 1'b0, 32'd0);
        end
        wb_burst(1'b1, BTE_LINEAR, 8, 3, 0, 1'b0, cyc);
        check("gap_burst_cycles", 32'(cyc), 32'd11);
        for (int i = 0; i < 8; i++) do_read(32'h8000_0000 + 32'(4 * i), 32'h2222_0000 + 32'(i));

        // Out-of-window accesses: first word past the window and below base.
        do_err(1'b1, 32'h8000_1000);
        do_err(1'b0, 32'h7FFF_FFFC);
        do_read(32'h8000_0000, 32'h2222_0000);

        // cyc dropped after beat 2 of an 8-beat write.
        do_write(32'h8000_0048, 32'h0BAD_0018, 4'hF);
        for (int i = 0; i < 8; i++) begin
            b_adr[i] = 32'h8000_0040 + 32'(4 * i);
            b_dat[i] = 32'h3333_0000 + 32'(i);
        end
        push(1'b0, 1'b0, 32'd0);
        push(1'b0, 1'b0, 32'd0);
        wb_burst(1'b1, BTE_LINEAR, 8, 0, 2, 1'b0, cyc);
        check("drop_burst_cycles", 32'(cyc), 32'd3);
        @(negedge clk);
        check("drop_ack_low", 32'(wb_ack_o), 32'd0);
        do_read(32'h8000_0040, 32'h3333_0000);
        do_read(32'h8000_0044, 32'h3333_0001);
        do_read(32'h8000_0048, 32'h0BAD_0018);

        // Asynchronous reset in the middle of a read burst.
        push(1'b0, 1'b1, 32'h2222_0000);
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = 32'h8000_0000; wb_cti_i = CTI_INCR; wb_bte_i = BTE_LINEAR;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        wb_adr_i = 32'h8000_0004;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ack", 32'(wb_ack_o), 32'd0);
        check("midrst_err", 32'(wb_err_o), 32'd0);
        check("midrst_dat", wb_dat_o, 32'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = CTI_CLASSIC;
        @(negedge clk);
        rst_n = 1'b1;
        do_read(32'h8000_0040, 32'h3333_0000);

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
